fetch_stage: RTL and testbench

- Instruction fetch stage of the 9-bit CPU. Sits directly upstream of decode, control and ALU-control.
- Holds the PC, reads the combinational instruction ROM and registers the fetched word into instr_out.
- Resolves taken branches through a target lookup table.
- Runs a start/done program handshake with the testbench or top level.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 39 +++
 rtl/fetch_stage_branch_lut.sv | 25 ++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit CPU: fetch FSM states, datapath widths,
// the halt encoding and the constant branch-target table read by branch_lut.
package cpu_pkg;

    localparam int PC_W      = 10;
    localparam int INSTR_W   = 9;
    localparam int LUT_DEPTH = 32;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Branch targets, indexed by the low five bits of the branching instruction.
    localparam pc_t BRANCH_TABLE [LUT_DEPTH] = '{
        10'd0,   10'd10,  10'd20,  10'd30,  10'd40,  10'd50,  10'd60,  10'd70,
        10'd80,  10'd90,  10'd100, 10'd110, 10'd120, 10'd130, 10'd140, 10'd150,
        10'd160, 10'd170, 10'd180, 10'd190, 10'd200, 10'd210, 10'd220, 10'd230,
        10'd240, 10'd250, 10'd260, 10'd270, 10'd280, 10'd290, 10'd300, 10'd310
    };

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its environment: program handshake,
// instruction ROM port, downstream stall/branch inputs and the fetched word.
// FETCH_PERF_CNT_EN adds the cycle_cnt / instr_cnt performance counters.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic   start;
    logic   done;
    pc_t    imem_addr;
    instr_t imem_data;
    logic   stall;
    logic   branch;
    logic   branch_taken;
    instr_t instr_out;
    logic   instr_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt;
    logic [15:0] instr_cnt;

    modport master (
        output start, imem_data, stall, branch, branch_taken,
        input  done, imem_addr, instr_out, instr_valid, cycle_cnt, instr_cnt
    );
    modport slave (
        input  start, imem_data, stall, branch, branch_taken,
        output done, imem_addr, instr_out, instr_valid, cycle_cnt, instr_cnt
    );
`else
    modport master (
        output start, imem_data, stall, branch, branch_taken,
        input  done, imem_addr, instr_out, instr_valid
    );
    modport slave (
        input  start, imem_data, stall, branch, branch_taken,
        output done, imem_addr, instr_out, instr_valid
    );
`endif

endinterface

// File: rtl/fetch_stage_branch_lut.sv
// Combinational branch-target lookup. Slots beyond the table depth read as 0
// so any 5-bit index always yields a defined target.
module branch_lut
    import cpu_pkg::*;
(
    input  logic [4:0] idx_i,
    output pc_t        target_o
);

    pc_t table_w [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_slot
            if (gi < LUT_DEPTH) begin : g_used
                assign table_w[gi] = BRANCH_TABLE[gi];
            end else begin : g_empty
                assign table_w[gi] = '0;
            end
        end
    endgenerate

    assign target_o = table_w[idx_i];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, registered ROM word with a valid flag,
// taken-branch redirect with a single squashed slot, and a start/done program
// handshake. Optional FETCH_PERF_CNT_EN adds saturating cycle/instr counters.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.slave  bus
);

    fetch_state_t state_q, state_d;
    pc_t          pc_q, pc_d;
    instr_t       instr_q, instr_d;
    logic         valid_q, valid_d;
    pc_t          target;
    logic         halt_fire;
    logic         br_fire;

    branch_lut u_branch_lut (
        .idx_i    (instr_q[4:0]),
        .target_o (target)
    );

    // Only a live (unsquashed) instruction can halt or branch; a stall freezes both.
    assign halt_fire = valid_q && (instr_q == HALT_INSTR) && !bus.stall;
    assign br_fire   = valid_q && bus.branch && bus.branch_taken && !bus.stall;

    // State, PC and fetched-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; halt outranks branch, and the word fetched alongside a
    // taken branch is loaded but marked invalid (the one-cycle bubble).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (halt_fire) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = bus.imem_data;
                        if (br_fire) begin
                            pc_d    = target;
                            valid_d = 1'b0;
                        end else begin
                            pc_d    = pc_q + pc_t'(1);
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                instr_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.done        = (state_q == HALT);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt_q;
    logic [15:0] instr_cnt_q;
    logic        start_run;

    assign start_run = (state_q != RUN) && bus.start;

    // Saturating counters, cleared whenever a start launches a new program.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else if (start_run) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if ((state_q == RUN) && (cycle_cnt_q != 16'hFFFF))
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
            if (valid_q && !bus.stall && (instr_cnt_q != 16'hFFFF))
                instr_cnt_q <= instr_cnt_q + 16'd1;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected per-cycle outputs are queued as each
// step is driven and popped/compared after the following rising edge.
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    logic [8:0] rom [1024];

    int tests;
    int fails;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_data = rom[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       v;
        logic       chk_i;
        logic [8:0] instr;
        logic [9:0] pc;
        logic       d;
    } exp_t;

    exp_t sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic v, input logic chk_i,
                            input logic [8:0] instr, input logic [9:0] pc, input logic d);
        exp_t e;
        e.tag = tag; e.v = v; e.chk_i = chk_i; e.instr = instr; e.pc = pc; e.d = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and compare the DUT against the oldest queued expectation.
    task automatic step();
        exp_t e;
        tick();
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            $display("[TB] %s pc=%0d instr=%h valid=%b done=%b", e.tag,
                     bus.imem_addr, bus.instr_out, bus.instr_valid, bus.done);
            check({e.tag, ".valid"}, 32'(bus.instr_valid), 32'(e.v));
            check({e.tag, ".pc"},    32'(bus.imem_addr),   32'(e.pc));
            check({e.tag, ".done"},  32'(bus.done),        32'(e.d));
            if (e.chk_i)
                check({e.tag, ".instr"}, 32'(bus.instr_out), 32'(e.instr));
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i & 255);
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.stall        = 1'b0;
        bus.branch       = 1'b0;
        bus.branch_taken = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst.instr", 32'(bus.instr_out), 32'h0);
        check("rst.valid", 32'(bus.instr_valid), 32'h0);
        check("rst.done",  32'(bus.done), 32'h0);
        check("rst.pc",    32'(bus.imem_addr), 32'h0);
        #2 rst_n = 1'b1;
        tick();

        // Sequential run ending in HALT; halt outranks a simultaneous taken branch
        rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h012; rom[3] = 9'h1FF;
        bus.start = 1'b1;
        push_exp("seq.start", 1'b0, 1'b0, 9'h000, 10'd0, 1'b0); step();
        bus.start = 1'b0;
        push_exp("seq.i0", 1'b1, 1'b1, 9'h010, 10'd1, 1'b0); step();
        push_exp("seq.i1", 1'b1, 1'b1, 9'h011, 10'd2, 1'b0); step();
        push_exp("seq.i2", 1'b1, 1'b1, 9'h012, 10'd3, 1'b0); step();
        push_exp("seq.i3", 1'b1, 1'b1, 9'h1FF, 10'd4, 1'b0); step();
        bus.branch = 1'b1; bus.branch_taken = 1'b1;
        push_exp("seq.halt", 1'b0, 1'b0, 9'h000, 10'd4, 1'b1); step();
        bus.branch = 1'b0; bus.branch_taken = 1'b0;
        push_exp("seq.frozen", 1'b0, 1'b0, 9'h000, 10'd4, 1'b1); step();

        // Restart from HALT, taken branch at PC 2 (lut[2]=20); fall-through is 1FF
        rom[0] = 9'h000; rom[1] = 9'h001; rom[2] = 9'h002; rom[3] = 9'h1FF;
        bus.start = 1'b1;
        push_exp("rst_halt.start", 1'b0, 1'b0, 9'h000, 10'd0, 1'b0); step();
`ifdef FETCH_PERF_CNT_EN
        check("perf.cycle_clr", 32'(bus.cycle_cnt), 32'd0);
        check("perf.instr_clr", 32'(bus.instr_cnt), 32'd0);
`endif
        bus.start = 1'b0;
        push_exp("br.i0", 1'b1, 1'b1, 9'h000, 10'd1, 1'b0); step();
`ifdef FETCH_PERF_CNT_EN
        check("perf.cycle1", 32'(bus.cycle_cnt), 32'd1);
`endif
        push_exp("br.i1", 1'b1, 1'b1, 9'h001, 10'd2, 1'b0); step();
`ifdef FETCH_PERF_CNT_EN
        check("perf.cycle2", 32'(bus.cycle_cnt), 32'd2);
        check("perf.instr1", 32'(bus.instr_cnt), 32'd1);
`endif
        push_exp("br.i2", 1'b1, 1'b1, 9'h002, 10'd3, 1'b0); step();
        bus.branch = 1'b1; bus.branch_taken = 1'b1;
        push_exp("br.bubble", 1'b0, 1'b0, 9'h000, 10'd20, 1'b0); step();
        // branch still asserted: squashed slot must neither branch nor halt
        push_exp("br.target", 1'b1, 1'b1, 9'h014, 10'd21, 1'b0); step();
        bus.branch = 1'b0; bus.branch_taken = 1'b0;
        bus.start = 1'b1;
        push_exp("run.start_ignored", 1'b1, 1'b1, 9'h015, 10'd22, 1'b0); step();
        bus.start = 1'b0;
        rom[3] = 9'h003;

        // Not-taken branch at PC 2, then a 3-cycle stall holding a taken branch
        do_reset();
        bus.start = 1'b1;
        push_exp("nt.start", 1'b0, 1'b0, 9'h000, 10'd0, 1'b0); step();
        bus.start = 1'b0;
        push_exp("nt.i0", 1'b1, 1'b1, 9'h000, 10'd1, 1'b0); step();
        push_exp("nt.i1", 1'b1, 1'b1, 9'h001, 10'd2, 1'b0); step();
        push_exp("nt.i2", 1'b1, 1'b1, 9'h002, 10'd3, 1'b0); step();
        bus.branch = 1'b1; bus.branch_taken = 1'b0;
        push_exp("nt.i3", 1'b1, 1'b1, 9'h003, 10'd4, 1'b0); step();
        bus.branch = 1'b0;
        push_exp("nt.i4", 1'b1, 1'b1, 9'h004, 10'd5, 1'b0); step();
        bus.stall = 1'b1; bus.branch = 1'b1; bus.branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_exp("stall.hold", 1'b1, 1'b1, 9'h004, 10'd5, 1'b0); step();
        end
        bus.stall = 1'b0;
        push_exp("stall.br_bubble", 1'b0, 1'b0, 9'h000, 10'd40, 1'b0); step();
        bus.branch = 1'b0; bus.branch_taken = 1'b0;
        push_exp("stall.br_target", 1'b1, 1'b1, 9'h028, 10'd41, 1'b0); step();

        // Asynchronous reset at pc=7, then restart and run through the PC wrap
        do_reset();
        bus.start = 1'b1;
        push_exp("ar.start", 1'b0, 1'b0, 9'h000, 10'd0, 1'b0); step();
        bus.start = 1'b0;
        repeat (6) tick();
        push_exp("ar.pc7", 1'b1, 1'b1, 9'h006, 10'd7, 1'b0); step();
        #3 rst_n = 1'b0;
        #1;
        check("ar.instr", 32'(bus.instr_out), 32'h0);
        check("ar.valid", 32'(bus.instr_valid), 32'h0);
        check("ar.pc",    32'(bus.imem_addr), 32'h0);
        check("ar.done",  32'(bus.done), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("ar.cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        push_exp("ar.idle", 1'b0, 1'b1, 9'h000, 10'd0, 1'b0); step();
        bus.start = 1'b1;
        push_exp("ar.restart", 1'b0, 1'b0, 9'h000, 10'd0, 1'b0); step();
        bus.start = 1'b0;
        push_exp("ar.i0", 1'b1, 1'b1, 9'h000, 10'd1, 1'b0); step();
        repeat (1021) tick();
        push_exp("wrap.pc1023", 1'b1, 1'b1, 9'h0FE, 10'd1023, 1'b0); step();
        push_exp("wrap.pc0",    1'b1, 1'b1, 9'h0FF, 10'd0,    1'b0); step();
        push_exp("wrap.pc1",    1'b1, 1'b1, 9'h000, 10'd1,    1'b0); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
